// File: rtl/vga_frame_regs.sv
// Avalon-MM shadow/active register bank for the VGA ball display, committed at vblank start.
// Optional vblank interrupt: define VGA_FRAME_IRQ_EN to enable the pending flag on reg 7.
module vga_frame_regs #(
   parameter int         VACTIVE        = 480,
   parameter logic [7:0] BG_B_RESET     = 8'h80,
   parameter logic [7:0] BALL_COL_RESET = 8'h03
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [2:0]  address,
   input  logic [7:0]  writedata,
   output logic [7:0]  readdata,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   output logic [7:0]  bg_r,
   output logic [7:0]  bg_g,
   output logic [7:0]  bg_b,
   output logic [7:0]  ball_row,
   output logic [7:0]  ball_col,
   output logic        irq
);

   // Bus: a transfer occurs on any cycle with chipselect and write (or read) high;
   // there are no wait states and readdata is valid the cycle after a read.
   logic       wr_en;
   logic       rd_en;
   logic       vblank_start;
   logic       commit;
   logic [7:0] sh_r, sh_g, sh_b, sh_row, sh_col;
   logic [1:0] ctrl;
   logic [7:0] frame;
   logic       pending;
   logic [7:0] rd_mux;

   assign wr_en        = chipselect & write;
   assign rd_en        = chipselect & read;
   assign vblank_start = (vcount == 10'(VACTIVE)) && (hcount == 11'd0);
   assign commit       = vblank_start & ~ctrl[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_r     <= 8'h00;
         sh_g     <= 8'h00;
         sh_b     <= BG_B_RESET;
         sh_row   <= 8'h00;
         sh_col   <= BALL_COL_RESET;
         bg_r     <= 8'h00;
         bg_g     <= 8'h00;
         bg_b     <= BG_B_RESET;
         ball_row <= 8'h00;
         ball_col <= BALL_COL_RESET;
         ctrl     <= 2'b00;
         frame    <= 8'h00;
         readdata <= 8'h00;
      end else begin
         // Commit first so a same-cycle IMMEDIATE write below overrides it.
         if (commit) begin
            bg_r     <= sh_r;
            bg_g     <= sh_g;
            bg_b     <= sh_b;
            ball_row <= sh_row;
            ball_col <= sh_col;
         end
         if (wr_en) begin
            case (address)
               3'd0: begin sh_r   <= writedata; if (ctrl[0]) bg_r     <= writedata; end
               3'd1: begin sh_g   <= writedata; if (ctrl[0]) bg_g     <= writedata; end
               3'd2: begin sh_b   <= writedata; if (ctrl[0]) bg_b     <= writedata; end
               3'd3: begin sh_row <= writedata; if (ctrl[0]) ball_row <= writedata; end
               3'd4: begin sh_col <= writedata; if (ctrl[0]) ball_col <= writedata; end
               3'd5: ctrl <= writedata[1:0];
               default: ;
            endcase
         end
         if (vblank_start)
            frame <= frame + 8'd1;
         if (rd_en)
            readdata <= rd_mux;
      end
   end

`ifdef VGA_FRAME_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pending <= 1'b0;
      else if (vblank_start)
         pending <= 1'b1;
      else if (wr_en && address == 3'd7)
         pending <= 1'b0;
   end
   assign irq = pending;
`else
   assign pending = 1'b0;
   assign irq     = 1'b0;
`endif

   always_comb begin
      rd_mux = 8'h00;
      case (address)
         3'd0: rd_mux = sh_r;
         3'd1: rd_mux = sh_g;
         3'd2: rd_mux = sh_b;
         3'd3: rd_mux = sh_row;
         3'd4: rd_mux = sh_col;
         3'd5: rd_mux = {6'b0, ctrl};
         3'd6: rd_mux = frame;
         3'd7: rd_mux = {7'b0, pending};
         default: rd_mux = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_vga_frame_regs.sv
// Bench for vga_frame_regs: directed scenarios plus random bus/raster traffic
// checked every cycle against a register-map model.
module tb_vga_frame_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write, read;
   logic [2:0]  address;
   logic [7:0]  writedata;
   logic [7:0]  readdata;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [7:0]  bg_r, bg_g, bg_b, ball_row, ball_col;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   // reference state: index 0..4 = R, G, B, row, col
   logic [7:0] m_sh[5];
   logic [7:0] m_act[5];
   logic [1:0] m_ctrl;
   logic [7:0] m_frame;
   logic       m_pend;
   logic [7:0] m_rd;

   vga_frame_regs dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .hcount(hcount), .vcount(vcount),
      .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .ball_row(ball_row), .ball_col(ball_col),
      .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sh[0] = 8'h00; m_sh[1] = 8'h00; m_sh[2] = 8'h80; m_sh[3] = 8'h00; m_sh[4] = 8'h03;
      for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      m_ctrl = 2'b00; m_frame = 8'h00; m_pend = 1'b0; m_rd = 8'h00;
   endtask

   function automatic logic [7:0] model_read(input logic [2:0] a);
      if (a < 3'd5) return m_sh[a];
      if (a == 3'd5) return {6'b0, m_ctrl};
      if (a == 3'd6) return m_frame;
`ifdef VGA_FRAME_IRQ_EN
      return {7'b0, m_pend};
`else
      return 8'h00;
`endif
   endfunction

   task automatic check_outputs();
      check("bg_r", bg_r, m_act[0]);
      check("bg_g", bg_g, m_act[1]);
      check("bg_b", bg_b, m_act[2]);
      check("ball_row", ball_row, m_act[3]);
      check("ball_col", ball_col, m_act[4]);
      check("readdata", readdata, m_rd);
      check("irq", {7'b0, irq}, {7'b0, m_pend});
   endtask

   // One clock: apply the register-map rules to the inputs present at the edge.
   task automatic cycle();
      logic vbs;
      @(posedge clk);
      vbs = (vcount == 10'd480) && (hcount == 11'd0);
      if (chipselect && read) m_rd = model_read(address);
      if (vbs && !m_ctrl[1])
         for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
      if (chipselect && write) begin
         if (address < 3'd5) begin
            m_sh[address] = writedata;
            if (m_ctrl[0]) m_act[address] = writedata;
         end else if (address == 3'd5) begin
            m_ctrl = writedata[1:0];
         end
      end
`ifdef VGA_FRAME_IRQ_EN
      if (chipselect && write && address == 3'd7) m_pend = 1'b0;
      if (vbs) m_pend = 1'b1;
`endif
      if (vbs) m_frame = m_frame + 8'd1;
      #1;
      check_outputs();
   endtask

   task automatic idle_bus();
      chipselect = 1'b0; write = 1'b0; read = 1'b0; address = 3'd0; writedata = 8'h00;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
      cycle();
      idle_bus();
   endtask

   task automatic bus_read(input logic [2:0] a);
      chipselect = 1'b1; write = 1'b0; read = 1'b1; address = a;
      cycle();
      idle_bus();
   endtask

   task automatic set_pos(input logic [9:0] v, input logic [10:0] h);
      vcount = v; hcount = h;
   endtask

   task automatic vblank();
      set_pos(10'd480, 11'd0);
      cycle();
      set_pos(10'd100, 11'd5);
   endtask

   // Asynchronous reset between edges: outputs must clear with no clock edge.
   task automatic do_reset();
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("rst_bg_r", bg_r, 8'h00);
      check("rst_bg_b", bg_b, 8'h80);
      check("rst_ball_col", ball_col, 8'h03);
      check("rst_readdata", readdata, 8'h00);
      check("rst_irq", {7'b0, irq}, 8'h00);
      model_reset();
      idle_bus();
      set_pos(10'd100, 11'd5);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_bus();
      set_pos(10'd100, 11'd5);
      model_reset();
      #25;
      check_outputs();
      @(negedge clk);
      reset = 1'b0;
      cycle();

      // deferred commit
      bus_write(3'd0, 8'h5A);
      check("defer_bg_r", bg_r, 8'h00);
      bus_read(3'd0);
      check("defer_rd0", readdata, 8'h5A);
      set_pos(10'd480, 11'd1);
      cycle();
      set_pos(10'd479, 11'd0);
      cycle();
      check("near_miss_bg_r", bg_r, 8'h00);
      vblank();
      check("commit_bg_r", bg_r, 8'h5A);
      bus_read(3'd6);
      check("frame1", readdata, 8'h01);

`ifdef VGA_FRAME_IRQ_EN
      check("irq_set", {7'b0, irq}, 8'h01);
      bus_read(3'd7);
      check("irq_rd7", readdata, 8'h01);
      bus_write(3'd7, 8'h00);
      check("irq_clr", {7'b0, irq}, 8'h00);
      set_pos(10'd480, 11'd0);
      bus_write(3'd7, 8'h00);
      set_pos(10'd100, 11'd5);
      check("irq_set_wins", {7'b0, irq}, 8'h01);
`else
      check("irq_off", {7'b0, irq}, 8'h00);
      bus_read(3'd7);
      check("rd7_off", readdata, 8'h00);
`endif

      // collision of write and commit
      bus_write(3'd1, 8'h11);
      vblank();
      set_pos(10'd480, 11'd0);
      bus_write(3'd1, 8'h33);
      set_pos(10'd100, 11'd5);
      check("coll_bg_g", bg_g, 8'h11);
      vblank();
      check("coll_bg_g_next", bg_g, 8'h33);

      // IMMEDIATE
      bus_write(3'd5, 8'hFD);
      bus_read(3'd5);
      check("ctrl_mask", readdata, 8'h01);
      bus_write(3'd3, 8'h40);
      check("imm_row", ball_row, 8'h40);

      // FREEZE
      do_reset();
      bus_write(3'd5, 8'h02);
      bus_write(3'd4, 8'h10);
      vblank(); cycle(); vblank();
      check("freeze_col", ball_col, 8'h03);
      bus_read(3'd6);
      check("freeze_frame", readdata, 8'h02);
      bus_write(3'd6, 8'hAA);
      bus_read(3'd6);
      check("frame_ro", readdata, 8'h02);

      // frame counter wrap
      do_reset();
      for (int f = 0; f < 256; f++) begin
         vblank();
         cycle();
      end
      chipselect = 1'b1; read = 1'b1; address = 3'd6;
      #1 check("rd_before_edge", readdata, 8'h00);
      cycle();
      idle_bus();
      check("frame_wrap", readdata, 8'h00);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0)      set_pos(10'd480, 11'd0);
         else if (r == 1) set_pos(10'd480, 11'd1);
         else if (r == 2) set_pos(10'd479, 11'd0);
         else set_pos(10'($urandom_range(0, 524)), 11'($urandom_range(0, 799)));
         chipselect = ($urandom_range(0, 3) != 0);
         write      = 1'($urandom_range(0, 1));
         read       = 1'($urandom_range(0, 1));
         address    = 3'($urandom_range(0, 7));
         writedata  = 8'($urandom);
         cycle();
         if (n == 2000) begin
            do_reset();
            cycle();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vga_frame_regs.md
Name: vga_frame_regs

Overview:
- Avalon-MM register slave that sits directly upstream of the VGA ball display block and supplies its colour and position operands.
- Holds a shadow copy and an active copy of each display parameter. Software writes the shadow copy.
- The shadow set is copied into the active set atomically at the start of vertical blanking, so the raster never shows a half-updated frame.
- Also provides a frame counter, readback, and a vblank interrupt.

Parameters:
- VACTIVE, 480, first non-visible line; commit happens when vcount reaches this value.
- BG_B_RESET, 8'h80, reset value of the blue background register.
- BALL_COL_RESET, 8'h03, reset value of the ball column register.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- chipselect  in  1  Avalon select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  3  register index
- writedata  in  8  write data
- readdata  out  8  read data, registered
- hcount  in  11  from the VGA counters
- vcount  in  10  from the VGA counters
- bg_r, bg_g, bg_b  out  8 each  active background colour
- ball_row  out  8  active ball row (compared against vcount[8:1])
- ball_col  out  8  active ball column
- irq  out  1  vblank interrupt, level

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset; every flop clears immediately when reset is asserted.
- Register map, 8 bits each:
  - 0 R shadow, 1 G shadow, 2 B shadow, 3 ball row shadow, 4 ball column shadow: R/W, reads return the shadow value.
  - 5 CTRL: bit0 IMMEDIATE, bit1 FREEZE, other bits read 0.
  - 6 FRAME: read-only 8-bit frame counter; writes ignored.
  - 7 IRQ: see Optional Feature.
- Write: when chipselect & write, the addressed shadow register takes writedata on the next clk edge.
- IMMEDIATE=1: a write to 0–4 also updates the matching active register in the same edge.
- vblank_start: a single-cycle strobe, true when vcount==VACTIVE and hcount==0. It fires once per frame.
- Commit: on vblank_start with FREEZE=0, all five active registers take the shadow values in one edge, and FRAME increments (wraps 255→0).
  - FREEZE=1: no commit, but FRAME still increments.
- Simultaneous write and commit in the same cycle:
  - The active registers take the pre-write shadow value.
  - The shadow register takes writedata.
  - The new value commits at the next vblank unless IMMEDIATE=1, in which case the active register takes writedata (the write wins).
- Read:
  - readdata updates one cycle after a chipselect & read cycle.
  - It holds its value otherwise.
  - It returns the register value as of the read cycle (before any same-cycle write).
- Reset values:
  - Shadow and active: R=0, G=0, B=BG_B_RESET, row=0, column=BALL_COL_RESET.
  - CTRL=0, FRAME=0, readdata=0, irq=0.
- Outputs bg_*, ball_row and ball_col are driven directly from the active flops; there is no combinational path from writedata.
- Writes to unused CTRL bits are discarded.

Optional Feature:
- Macro: VGA_FRAME_IRQ_EN.
- Defined:
  - A pending flag sets on every vblank_start; irq equals the flag.
  - Reading reg 7 returns {7'b0, pending}.
  - Any write to reg 7 clears pending.
  - If the set and the clear coincide in the same cycle, set wins.
- Undefined: irq is tied 0, reg 7 reads 0, and writes to reg 7 are ignored.

Test Plan:
- Reset check: assert reset mid-frame → all outputs at reset values immediately, with no clk edge needed; B=0x80, ball_col=0x03, FRAME=0, irq=0.
- Deferred commit: write R=0x5A at vcount=100 → bg_r stays 0x00 until the vblank_start edge (vcount=480, hcount=0), then bg_r=0x5A and FRAME=1; reading reg 0 before vblank returns 0x5A.
- Collision: write G=0x33 in the exact vblank_start cycle with shadow G=0x11 → bg_g=0x11 after that edge, bg_g=0x33 after the next vblank.
- Control bits:
  - CTRL=0x01, then write row=0x40 → ball_row=0x40 on the next edge.
  - CTRL=0x02, then write col=0x10, run 2 frames → ball_col unchanged and FRAME advanced by 2.
- Counter wrap: run 256 frames → FRAME wraps to 0; readdata appears exactly 1 cycle after the read strobe.
- IRQ (with VGA_FRAME_IRQ_EN): irq rises after vblank_start and reg 7 reads 0x01. A write to reg 7 drops irq next cycle; a write coincident with vblank_start leaves irq=1. Without the macro, irq stays 0 throughout.
